// File: rtl/fetcher_pkg.sv
// Shared constants, types and FSM encoding for the instruction fetcher.
package fetcher_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned INST_WIDTH = 32;

   typedef logic [ADDR_WIDTH-1:0] ADDR_TYPE;
   typedef logic [INST_WIDTH-1:0] INST_TYPE;

   // Opcode field position inside an instruction word
   localparam int unsigned OPCODE_MSB = 6;
   localparam int unsigned OPCODE_LSB = 0;
   typedef logic [OPCODE_MSB:OPCODE_LSB] OPCODE_RANGE;

   localparam OPCODE_RANGE OPCODE_JAL    = 7'b1101111;
   localparam OPCODE_RANGE OPCODE_BRANCH = 7'b1100011;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   // Byte stride between sequential instructions
   localparam ADDR_TYPE INST_BYTES = 32'd4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      HOLD     = 2'd2,
      DRAIN    = 2'd3
   } fetch_state_t;

   // Address of the instruction after pc; wraps modulo 2^32.
   function automatic ADDR_TYPE next_pc(input ADDR_TYPE pc, input ADDR_TYPE imm,
                                        input logic taken);
      return taken ? (pc + imm) : (pc + INST_BYTES);
   endfunction

   function automatic OPCODE_RANGE opcode_of(input INST_TYPE inst);
      return inst[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetcher.sv
// Instruction fetcher: requests one word at a time from memory, holds it for the
// branch predictor, hands it to the instruction queue and follows ROB rollbacks.
module fetcher
   import fetcher_pkg::*;
(
   input  logic     clk_in,
   input  logic     rst_in,
   input  logic     rdy_in,
   // memory controller
   output logic     mem_req_out,
   output ADDR_TYPE mem_addr_out,
   input  logic     mem_done_in,
   input  INST_TYPE mem_inst_in,
   // branch predictor
   output ADDR_TYPE pc_to_predictor,
   output INST_TYPE inst_to_predictor,
   input  ADDR_TYPE imm_from_predictor,
   input  logic     jump_predict_flag_from_predictor,
   // instruction queue
   input  logic     queue_full_in,
   output logic     issue_valid_out,
   output ADDR_TYPE issue_pc_out,
   output INST_TYPE issue_inst_out,
   output logic     issue_jump_flag_out,
   // reorder buffer
   input  logic     rollback_in,
   input  ADDR_TYPE rollback_pc_in
);

   fetch_state_t state_q, state_d;
   ADDR_TYPE     pc_q, pc_d;
   INST_TYPE     inst_q, inst_d;
   logic         issue_fire;
   logic         word_latch;

   // Handoff happens only when not frozen, not flushed, and the queue has room
   assign issue_fire = (state_q == HOLD) && rdy_in && !rollback_in && !queue_full_in;

   // Returned word is kept only for a live request that is not being flushed
   assign word_latch = (state_q == WAIT_MEM) && rdy_in && !rollback_in && mem_done_in;

   // State register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // PC and held-instruction registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pc_q   <= '0;
         inst_q <= '0;
      end else begin
         pc_q   <= pc_d;
         inst_q <= inst_d;
      end
   end

   // Next state: rollback wins; an in-flight request is drained so that at most
   // one memory request is ever outstanding
   always_comb begin
      state_d = state_q;
      if (rdy_in) begin
         if (rollback_in) begin
            if (((state_q == WAIT_MEM) || (state_q == DRAIN)) && !mem_done_in) begin
               state_d = DRAIN;
            end else begin
               state_d = IDLE;
            end
         end else begin
            unique case (state_q)
               IDLE:     state_d = WAIT_MEM;
               WAIT_MEM: if (mem_done_in) state_d = HOLD;
               HOLD:     if (!queue_full_in) state_d = IDLE;
               DRAIN:    if (mem_done_in) state_d = IDLE;
               default:  state_d = IDLE;
            endcase
         end
      end
   end

   // Next PC and held instruction
   always_comb begin
      pc_d   = pc_q;
      inst_d = inst_q;
      if (rdy_in) begin
         if (rollback_in) begin
            pc_d = rollback_pc_in;
         end else if (issue_fire) begin
            pc_d = next_pc(pc_q, imm_from_predictor, jump_predict_flag_from_predictor);
         end
      end
      if (word_latch) begin
         inst_d = mem_inst_in;
      end
   end

   // Outputs: all zero outside the states that own them
   always_comb begin
      mem_req_out         = FALSE;
      mem_addr_out        = '0;
      pc_to_predictor     = '0;
      inst_to_predictor   = '0;
      issue_valid_out     = FALSE;
      issue_pc_out        = '0;
      issue_inst_out      = '0;
      issue_jump_flag_out = FALSE;
      unique case (state_q)
         WAIT_MEM: begin
            mem_req_out  = TRUE;
            mem_addr_out = pc_q;
         end
         HOLD: begin
            pc_to_predictor   = pc_q;
            inst_to_predictor = inst_q;
            if (issue_fire) begin
               issue_valid_out     = TRUE;
               issue_pc_out        = pc_q;
               issue_inst_out      = inst_q;
               issue_jump_flag_out = jump_predict_flag_from_predictor;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fetcher.sv
// Bench for the fetcher: directed vector table, async reset sequence, then
// randomized traffic checked against a transaction-level reference model.
module tb_fetcher;
   import fetcher_pkg::*;

   logic     clk_in = 1'b0;
   logic     rst_in;
   logic     rdy_in;
   logic     mem_req_out;
   ADDR_TYPE mem_addr_out;
   logic     mem_done_in;
   INST_TYPE mem_inst_in;
   ADDR_TYPE pc_to_predictor;
   INST_TYPE inst_to_predictor;
   ADDR_TYPE imm_from_predictor;
   logic     jump_predict_flag_from_predictor;
   logic     queue_full_in;
   logic     issue_valid_out;
   ADDR_TYPE issue_pc_out;
   INST_TYPE issue_inst_out;
   logic     issue_jump_flag_out;
   logic     rollback_in;
   ADDR_TYPE rollback_pc_in;

   fetcher dut (
      .clk_in                          (clk_in),
      .rst_in                          (rst_in),
      .rdy_in                          (rdy_in),
      .mem_req_out                     (mem_req_out),
      .mem_addr_out                    (mem_addr_out),
      .mem_done_in                     (mem_done_in),
      .mem_inst_in                     (mem_inst_in),
      .pc_to_predictor                 (pc_to_predictor),
      .inst_to_predictor               (inst_to_predictor),
      .imm_from_predictor              (imm_from_predictor),
      .jump_predict_flag_from_predictor(jump_predict_flag_from_predictor),
      .queue_full_in                   (queue_full_in),
      .issue_valid_out                 (issue_valid_out),
      .issue_pc_out                    (issue_pc_out),
      .issue_inst_out                  (issue_inst_out),
      .issue_jump_flag_out             (issue_jump_flag_out),
      .rollback_in                     (rollback_in),
      .rollback_pc_in                  (rollback_pc_in)
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        rdy, qf, done;
      logic [31:0] inst;
      logic        flag;
      logic [31:0] imm;
      logic        rb;
      logic [31:0] rbpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_ipc, e_iinst;
      logic        e_iflag;
      logic [31:0] e_ppc, e_pinst;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [31:0] rdy, qf, done, inst, flag, imm, rb, rbpc,
                               input logic [31:0] e_req, e_addr, e_iv, e_ipc, e_iinst,
                               input logic [31:0] e_iflag, e_ppc, e_pinst);
      vec_t r;
      r.rdy = rdy[0];     r.qf = qf[0];         r.done = done[0];    r.inst = inst;
      r.flag = flag[0];   r.imm = imm;          r.rb = rb[0];        r.rbpc = rbpc;
      r.e_req = e_req[0]; r.e_addr = e_addr;    r.e_iv = e_iv[0];    r.e_ipc = e_ipc;
      r.e_iinst = e_iinst; r.e_iflag = e_iflag[0]; r.e_ppc = e_ppc;  r.e_pinst = e_pinst;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_iv, input logic [31:0] e_ipc, input logic [31:0] e_iinst,
                            input logic e_iflag, input logic [31:0] e_ppc,
                            input logic [31:0] e_pinst);
      check({tag, ".mem_req"},   32'(mem_req_out),         32'(e_req));
      check({tag, ".mem_addr"},  mem_addr_out,             e_addr);
      check({tag, ".issue_vld"}, 32'(issue_valid_out),     32'(e_iv));
      check({tag, ".issue_pc"},  issue_pc_out,             e_ipc);
      check({tag, ".issue_ins"}, issue_inst_out,           e_iinst);
      check({tag, ".issue_jmp"}, 32'(issue_jump_flag_out), 32'(e_iflag));
      check({tag, ".pred_pc"},   pc_to_predictor,          e_ppc);
      check({tag, ".pred_ins"},  inst_to_predictor,        e_pinst);
   endtask

   task automatic drive(input logic rdy, qf, done, input logic [31:0] inst, input logic flag,
                        input logic [31:0] imm, input logic rb, input logic [31:0] rbpc);
      rdy_in = rdy;  queue_full_in = qf;  mem_done_in = done;  mem_inst_in = inst;
      jump_predict_flag_from_predictor = flag;  imm_from_predictor = imm;
      rollback_in = rb;  rollback_pc_in = rbpc;
   endtask

   // Reference model: request open / response to discard / word held for issue
   bit          m_req, m_drop, m_held;
   logic [31:0] m_pc, m_inst;
   // Memory responder
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_word;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0000_0013;
   endfunction

   task automatic model_reset();
      m_req = 0; m_drop = 0; m_held = 0; m_pc = '0; m_inst = '0;
      mem_busy = 0; mem_cnt = 0; mem_word = '0;
   endtask

   localparam logic [31:0] ADDI = 32'h0000_0013;
   localparam logic [31:0] BEQ  = 32'h00c0_0063;
   localparam logic [31:0] JAL  = 32'h0200_006F;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   initial begin
      logic        rdy, qf, done, flag, rb, e_fire;
      logic [31:0] inst, imm, rbpc;

      rst_in = 1'b0;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      model_reset();

      // rdy qf dn inst flg imm rb rbpc | req addr iv ipc iinst iflg ppc pinst
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));      // IDLE after reset
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(1,0,0,0,0,0,0,0,   1,0,0,0,0,0,0,0));      // request at 0
      vecs.push_back(mk(1,0,1,ADDI,0,0,0,0,   1,0,0,0,0,0,0,0));      // done, 3 cycles later
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,1,0,ADDI,0,0,ADDI));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,1,BEQ,0,0,0,0,    1,4,0,0,0,0,0,0));      // sequential pc+4
      vecs.push_back(mk(1,0,0,0,1,32'hC,0,0,  0,0,1,4,BEQ,1,4,BEQ));  // taken branch -> 0x10
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,1,JAL,0,0,0,0,    1,32'h10,0,0,0,0,0,0));
      for (int k = 0; k < 5; k++)                                     // queue full 5 cycles
         vecs.push_back(mk(1,1,0,0,1,32'h20,0,0, 0,0,0,0,0,0,32'h10,JAL));
      vecs.push_back(mk(1,0,0,0,1,32'h20,0,0, 0,0,1,32'h10,JAL,1,32'h10,JAL));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,1,ADDI,0,0,0,0,   1,32'h30,0,0,0,0,0,0)); // JAL target
      vecs.push_back(mk(1,0,0,0,1,32'h10,0,0, 0,0,1,32'h30,ADDI,1,32'h30,ADDI));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,1,32'h100, 1,32'h40,0,0,0,0,0,0)); // rollback in WAIT_MEM
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));      // DRAIN
      vecs.push_back(mk(1,0,1,JUNK,0,0,0,0,   0,0,0,0,0,0,0,0));      // stale word discarded
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,1,ADDI,0,0,1,32'h200, 1,32'h100,0,0,0,0,0,0)); // rollback + done
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,1,ADDI,0,0,0,0,   1,32'h200,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,      0,0,0,0,0,0,32'h200,ADDI)); // frozen in HOLD
      vecs.push_back(mk(0,0,1,JUNK,1,4,1,32'h300, 0,0,0,0,0,0,32'h200,ADDI));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,      0,0,0,0,0,0,32'h200,ADDI));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,      0,0,0,0,0,0,32'h200,ADDI));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,1,32'h200,ADDI,0,32'h200,ADDI));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,1,32'hFFFF_FFFC, 1,32'h204,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,1,JUNK,0,0,0,0,   0,0,0,0,0,0,0,0));      // DRAIN done
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,1,ADDI,0,0,0,0,   1,32'hFFFF_FFFC,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,1,32'hFFFF_FFFC,ADDI,0,32'hFFFF_FFFC,ADDI));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,      1,0,0,0,0,0,0,0));      // pc wrapped to 0

      repeat (3) @(posedge clk_in);
      #2 rst_in = 1'b1;  // release in the high phase, before the next rising edge

      foreach (vecs[i]) begin
         @(negedge clk_in);
         drive(vecs[i].rdy, vecs[i].qf, vecs[i].done, vecs[i].inst, vecs[i].flag,
               vecs[i].imm, vecs[i].rb, vecs[i].rbpc);
         #2;
         check_all($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                   vecs[i].e_ipc, vecs[i].e_iinst, vecs[i].e_iflag, vecs[i].e_ppc,
                   vecs[i].e_pinst);
      end

      // Async reset between edges while WAIT_MEM: outputs drop before any edge
      @(negedge clk_in);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      #3 rst_in = 1'b0;
      #1 check_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk_in);
      #2 rst_in = 1'b1;
      @(negedge clk_in);
      #2 check_all("restart_idle", 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk_in);
      #2 check_all("restart_req", 1, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic against the reference model
      @(negedge clk_in);
      #3 rst_in = 1'b0;
      @(posedge clk_in);
      #2 rst_in = 1'b1;
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk_in);
         rdy  = ($urandom_range(0, 9) != 0);
         qf   = ($urandom_range(0, 2) == 0);
         flag = ($urandom_range(0, 2) == 0);
         imm  = 32'($urandom_range(0, 127)) * 32'd4 - 32'd256;
         rb   = ($urandom_range(0, 15) == 0);
         rbpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         done = mem_busy && (mem_cnt == 0) && rdy;
         inst = done ? mem_word : $urandom;
         drive(rdy, qf, done, inst, flag, imm, rb, rbpc);
         #2;
         e_fire = m_held && rdy && !rb && !qf;
         check_all("rand", m_req, m_req ? m_pc : 32'h0, e_fire, e_fire ? m_pc : 32'h0,
                   e_fire ? m_inst : 32'h0, e_fire && flag, m_held ? m_pc : 32'h0,
                   m_held ? m_inst : 32'h0);
         @(posedge clk_in);
         if (rdy) begin
            if (rb) begin
               m_drop = (m_req || m_drop) && !done;
               m_req  = 0;
               m_held = 0;
               m_pc   = rbpc;
            end else if (m_req) begin
               if (done) begin
                  m_inst = inst; m_req = 0; m_held = 1;
               end
            end else if (m_held) begin
               if (!qf) begin
                  m_pc   = m_pc + (flag ? imm : 32'd4);
                  m_held = 0;
               end
            end else if (m_drop) begin
               if (done) m_drop = 0;
            end else begin
               m_req = 1;
            end
         end
         if (done) mem_busy = 0;
         else if (mem_busy && mem_cnt > 0) mem_cnt--;
         if (m_req && !mem_busy) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(1, 3);
            mem_word = word_of(m_pc);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 SHALL expose: clk_in, input, 1, the single clock; all state is updated on its rising edge.
REQ-002 SHALL expose: rst_in, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL expose: rdy_in, input, 1, global ready; when low, all state holds.
REQ-004 SHALL expose: mem_req_out, output, 1, instruction-fetch request to the memory controller.
REQ-005 SHALL expose: mem_addr_out, output, ADDR_TYPE, fetch address.
REQ-006 SHALL expose: mem_done_in, input, 1, one-cycle pulse marking a returned word.
REQ-007 SHALL expose: mem_inst_in, input, INST_TYPE, the returned word, valid with mem_done_in.
REQ-008 SHALL expose: pc_to_predictor, output, ADDR_TYPE, PC of the held instruction.
REQ-009 SHALL expose: inst_to_predictor, output, INST_TYPE, the held instruction.
REQ-010 SHALL expose: imm_from_predictor, input, ADDR_TYPE, branch or JAL offset.
REQ-011 SHALL expose: jump_predict_flag_from_predictor, input, 1, predicted taken.
REQ-012 SHALL expose: queue_full_in, input, 1, the instruction queue cannot accept.
REQ-013 SHALL expose: issue_valid_out, output, 1, one-cycle instruction handoff.
REQ-014 SHALL expose: issue_pc_out, output, ADDR_TYPE, PC of the issued instruction.
REQ-015 SHALL expose: issue_inst_out, output, INST_TYPE, the issued instruction.
REQ-016 SHALL expose: issue_jump_flag_out, output, 1, the prediction sent with it.
REQ-017 SHALL expose: rollback_in, input, 1, ROB misprediction flush.
REQ-018 SHALL expose: rollback_pc_in, input, ADDR_TYPE, the corrected PC.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_MEM, HOLD, DRAIN, with state, pc, and instruction registers.
REQ-020 IDLE SHALL go to WAIT_MEM next cycle, with mem_req_out=1 and mem_addr_out=pc.
REQ-021 WAIT_MEM SHALL hold mem_req_out=1 and mem_addr_out stable until mem_done_in.
- On mem_done_in: latch mem_inst_in, go to HOLD.
- mem_req_out SHALL be 0 from the next cycle.
REQ-022 HOLD SHALL drive pc_to_predictor=pc and inst_to_predictor=latched instruction; these are combinational and valid in HOLD only, else 0.
REQ-023 HOLD with queue_full_in=0 SHALL pulse issue_valid_out=1 for exactly one cycle.
- Payload: pc, the instruction, and jump_predict_flag_from_predictor.
- Same edge: pc <= flag ? pc+imm_from_predictor : pc+4; go to IDLE.
REQ-024 HOLD with queue_full_in=1 SHALL stay in HOLD, with issue_valid_out=0 and the held instruction unchanged.
REQ-025 PC arithmetic SHALL be 32-bit modulo 2^32; 0xFFFFFFFC+4 SHALL give 0x00000000.
REQ-026 Latency SHALL be one cycle from the mem_done_in edge to issue_valid_out, when the queue is not full.
REQ-027 rollback_in SHALL take priority over every other event in any state.
- pc <= rollback_pc_in; issue_valid_out=0 that cycle.
- From WAIT_MEM, with mem_done_in not in the same cycle: go to DRAIN.
- From any other state, or when mem_done_in coincides: go to IDLE and discard the returned word.
REQ-028 DRAIN SHALL drop mem_req_out, wait for mem_done_in, discard the word, then go to IDLE.
- A further rollback_in in DRAIN SHALL only update pc.
REQ-029 rdy_in=0 SHALL freeze state, pc, and the held instruction.
- issue_valid_out=0 while frozen.
- rollback_in and mem_done_in are ignored.
- mem_req_out and mem_addr_out hold their values.
REQ-030 The block SHALL never have more than one outstanding memory request.

Reset
REQ-031 rst_in low SHALL immediately force state=IDLE, pc=0x00000000, and the held instruction to 0.
- Every output SHALL read 0.
REQ-032 Reset mid-request SHALL abandon the request; the memory controller is reset by the same rst_in.
REQ-033 The first request SHALL go out to address 0 in the second rising edge after rst_in deasserts, with rdy_in=1.

Structure
REQ-034 ADDR_TYPE, INST_TYPE, OPCODE_RANGE, OPCODE_JAL, OPCODE_BRANCH, TRUE/FALSE, and the FSM state encodings SHALL live in the shared constants include.
REQ-035 The block SHALL be one module with no sub-modules; it connects directly to the branch predictor, the memory controller, the instruction queue, and the ROB.

Verification
REQ-036 Sequential fetch: memory returns 0x00000013 (addi) at 0x0, done 3 cycles after request -> issue_pc_out=0x0 one cycle after done, next mem_addr_out=0x4.
REQ-037 Predicted JAL at 0x10: imm=0x20, flag=1 -> issue_jump_flag_out=1, next mem_addr_out=0x30.
REQ-038 Backpressure: queue_full_in=1 for 5 cycles in HOLD -> no issue, no new request; single issue_valid_out on the cycle it drops.
REQ-039 Rollback to 0x100 while WAIT_MEM at 0x40 -> DRAIN, the 0x40 word is never issued, next request goes to 0x100.
REQ-040 Rollback coinciding with mem_done_in, and with rdy_in=0 for 4 cycles mid-HOLD -> respectively: no issue and next fetch at the rollback target; state and outputs unchanged while frozen.
REQ-041 Async reset asserted mid-WAIT_MEM, between clock edges -> outputs 0 before the next edge; restart at 0x0.
